// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential 32-bit divider:
// FSM encoding, ready/start levels, widths and the operand sign helper.
package div_seq_pkg;

    localparam int DATA_W   = 32;
    localparam int RESULT_W = 64;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Two's-complement negate when en is set; used for both abs() and sign fix-up.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              en);
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder, trial-subtracts the divisor and emits one quotient bit.
module div_step
    import div_seq_pkg::*;
(
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] trial;
    logic            qbit;

    // Partial remainder is always below the divisor, so a non-negative trial fits in DATA_W bits.
    assign trial = {rem_i, quo_i[DATA_W-1]} - {1'b0, divisor_i};
    assign qbit  = ~trial[DATA_W];
    assign rem_o = qbit ? trial[DATA_W-1:0] : {rem_i[DATA_W-2:0], quo_i[DATA_W-1]};
    assign quo_o = {quo_i[DATA_W-2:0], qbit};

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit signed/unsigned divider, 32 steps per operation, with
// divide-by-zero short path, annul (flush) support and a pipeline stall request.
module div_seq
    import div_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [RESULT_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o
);

    div_state_e          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   rem_step, quo_step;

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_step),
        .quo_o     (quo_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            DIV_FREE: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = cond_neg(opdata1_i, signed_div_i & opdata1_i[DATA_W-1]);
                        dvs_d   = cond_neg(opdata2_i, signed_div_i & opdata2_i[DATA_W-1]);
                        negq_d  = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        negr_d  = signed_div_i & opdata1_i[DATA_W-1];
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DivResultReady;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == 6'd32) begin
                    state_d  = DIV_END;
                    result_d = {cond_neg(rem_q, negr_q), cond_neg(quo_q, negq_q)};
                    ready_d  = DivResultReady;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DIV_END: begin
                // Result is held until EX drops its request.
                if (start_i == DivStop) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: arithmetic vectors, latency,
// stall request, annul, operand isolation and asynchronous reset.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int total = 0;
    int bad   = 0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    // Drives a request and waits (bounded) for ready_o; stalls counts stallreq_o samples taken after each edge.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic scramble, output logic [63:0] res,
                          output int edges, output int stalls);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        stalls       = 0;
        while (edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
            if (scramble) begin
                opdata1_i    = ~a;
                opdata2_i    = b ^ 32'h5A5A_5A5A;
                signed_div_i = ~s;
            end
            if (stallreq_o) stalls++;
            if (ready_o) break;
        end
        res = result_o;
    endtask

    task automatic test_divide(input string name, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic scramble,
                               input logic [63:0] exp, input int exp_edges,
                               input int exp_stalls);
        logic [63:0] res;
        int edges, stalls;
        @(negedge clk);
        run_op(s, a, b, scramble, res, edges, stalls);
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL %s result: got %h want %h", name, res, exp);
        end
        total++;
        if (edges !== exp_edges) begin
            bad++;
            $display("FAIL %s latency: got %0d edges want %0d", name, edges, exp_edges);
        end
        total++;
        if (stalls !== exp_stalls) begin
            bad++;
            $display("FAIL %s stall: got %0d cycles want %0d", name, stalls, exp_stalls);
        end
        @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b1 || result_o !== exp) begin
            bad++;
            $display("FAIL %s hold: got ready=%b res=%h want ready=1 res=%h", name, ready_o, result_o, exp);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            bad++;
            $display("FAIL %s release: got ready=%b res=%h want ready=0 res=0", name, ready_o, result_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got ready=%b res=%h stall=%b want 0/0/0", ready_o, result_o, stallreq_o);
        end
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            bad++;
            $display("FAIL reset_hold: got ready=%b res=%h want 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        test_divide("u100_7", 1'b0, 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34, 33);
        test_divide("uffff_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 34, 33);
        test_divide("u8000_ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 34, 33);
    endtask

    task automatic test_signed();
        test_divide("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 33);
        test_divide("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, {32'd1, 32'hFFFF_FFFD}, 34, 33);
        test_divide("s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, {32'hFFFF_FFFE, 32'd14}, 34, 33);
        test_divide("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h0, 32'h8000_0000}, 34, 33);
    endtask

    task automatic test_byzero();
        test_divide("u_by0", 1'b0, 32'd123, 32'd0, 1'b0, 64'h0, 2, 1);
        test_divide("s_by0", 1'b1, 32'h8000_0000, 32'd0, 1'b0, 64'h0, 2, 1);
    endtask

    task automatic test_operand_change();
        test_divide("scramble", 1'b0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, 34, 33);
    endtask

    task automatic test_annul();
        int seen;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        total++;
        if (stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL annul_stall: got %b want 0", stallreq_o);
        end
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        total++;
        if (stallreq_o !== 1'b0 || ready_o !== 1'b0) begin
            bad++;
            $display("FAIL annul_drop: got stall=%b ready=%b want 0/0", stallreq_o, ready_o);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        total++;
        if (seen !== 0 || result_o !== 64'h0) begin
            bad++;
            $display("FAIL annul_noready: got %0d ready cycles res=%h want 0 and 0", seen, result_o);
        end
        // annul in BYZERO
        @(negedge clk);
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL annul_byzero: got ready=%b want 0", ready_o);
        end
        // annul held together with start in FREE must block a new operation
        opdata2_i = 32'd7;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL annul_priority: got %0d ready cycles want 0", seen);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        test_divide("after_annul", 1'b0, 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34, 33);
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        int edges, stalls, seen;
        @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, 1'b0, res, edges, stalls);
        total++;
        if (res !== {32'd2, 32'd14}) begin
            bad++;
            $display("FAIL areset_pre: got %h want %h", res, {32'd2, 32'd14});
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            bad++;
            $display("FAIL areset_end: got ready=%b res=%h want 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'h0 || dut.cnt_q !== 6'd0) begin
            bad++;
            $display("FAIL areset_on: got ready=%b res=%h cnt=%0d want 0/0/0", ready_o, result_o, dut.cnt_q);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL areset_noresume: got %0d ready cycles want 0", seen);
        end
        test_divide("after_reset", 1'b0, 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34, 33);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_byzero();
        test_operand_change();
        test_annul();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
